// File: rtl/cus19_muldiv_pkg.sv
// Shared definitions for the cus19 multiply/divide unit: op codes, FSM encoding and
// result constants for the default 8-bit configuration.
package cus19_muldiv_pkg;

   typedef enum logic [1:0] {
      OpMulu = 2'b00,
      OpMuls = 2'b01,
      OpDivu = 2'b10,
      OpDivs = 2'b11
   } op_e;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StCalc  = 2'd1;
   localparam logic [1:0] StFixup = 2'd2;
   localparam logic [1:0] StWb    = 2'd3;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned CalcCycles   = DefDataWidth;
   localparam logic [DefDataWidth-1:0] DivZeroQuo = '1;

   function automatic logic is_div(op_e op);
      return op[1];
   endfunction

   function automatic logic is_signed(op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/cus19_muldiv_if.sv
// Issue / write-back bundle between decode, the muldiv unit and the register file.
interface cus19_muldiv_if #(
   parameter int unsigned Data_Width     = 8,
   parameter int unsigned Reg_Addr_Width = 4
);
   logic                        start_in;
   logic [1:0]                  op_in;
   logic [Data_Width-1:0]       rs1_in;
   logic [Data_Width-1:0]       rs2_in;
   logic [Reg_Addr_Width-1:0]   rd_addr_in;
   logic                        flush_in;
   logic                        busy_out;
   logic                        done_out;
   logic                        wr_en_out;
   logic [Reg_Addr_Width-1:0]   wr_addr_out;
   logic [2*Data_Width-1:0]     wr_data_out;
   logic                        div_zero_out;

   modport master (
      output start_in, op_in, rs1_in, rs2_in, rd_addr_in, flush_in,
      input  busy_out, done_out, wr_en_out, wr_addr_out, wr_data_out, div_zero_out
   );

   modport slave (
      input  start_in, op_in, rs1_in, rs2_in, rd_addr_in, flush_in,
      output busy_out, done_out, wr_en_out, wr_addr_out, wr_data_out, div_zero_out
   );
endinterface

// File: rtl/cus19_muldiv_signfix.sv
// Combinational sign handling: operand magnitudes (operand side) or negation of
// product / quotient / remainder (result side). Unsigned ops pass straight through.
module cus19_muldiv_signfix
   import cus19_muldiv_pkg::*;
#(
   parameter int unsigned Data_Width  = 8,
   parameter bit          Result_Side = 1'b0
) (
   input  op_e                   op,
   input  logic                  sign_a,
   input  logic                  sign_b,
   input  logic [Data_Width-1:0] lo,
   input  logic [Data_Width-1:0] hi,
   output logic [Data_Width-1:0] lo_fixed,
   output logic [Data_Width-1:0] hi_fixed
);

   logic [2*Data_Width-1:0] pair_neg;

   assign pair_neg = -{hi, lo};

   always_comb begin
      lo_fixed = lo;
      hi_fixed = hi;
      if (is_signed(op)) begin
         if (!Result_Side) begin
            // lo carries rs1, hi carries rs2
            if (sign_a) lo_fixed = -lo;
            if (sign_b) hi_fixed = -hi;
         end else if (is_div(op)) begin
            // quotient truncates toward zero, remainder follows the dividend
            if (sign_a ^ sign_b) lo_fixed = -lo;
            if (sign_a)          hi_fixed = -hi;
         end else if (sign_a ^ sign_b) begin
            {hi_fixed, lo_fixed} = pair_neg;
         end
      end
   end

endmodule

// File: rtl/cus19_muldiv_unit.sv
// Iterative multiply / restoring divide unit feeding a register-pair write port.
// Optional: define CUS19_MULDIV_EARLY_OUT_EN for single-cycle trivial results.
module cus19_muldiv_unit
   import cus19_muldiv_pkg::*;
#(
   parameter int unsigned Data_Width     = 8,
   parameter int unsigned Reg_Addr_Width = 4
) (
   input logic         clk_in,
   input logic         rst_in,
   cus19_muldiv_if.slave bus
);

   localparam int unsigned W         = Data_Width;
   localparam int unsigned Cnt_Width = $clog2(W);
   localparam logic [Cnt_Width-1:0] Cnt_Init = Cnt_Width'(W - 1);

   logic [1:0]                state_q, state_d;
   op_e                       op_q;
   logic                      sign_a_q, sign_b_q;
   logic [W-1:0]              hi_q, lo_q, b_q;
   logic [Cnt_Width-1:0]      cnt_q;
   logic [Reg_Addr_Width-1:0] rd_q, wr_addr_q;
   logic [2*W-1:0]            result_q;
   logic                      div_zero_q;

   op_e          op_new;
   logic         start_ok, enter_wb;
   logic [W-1:0] a_mag, b_mag, fix_lo, fix_hi;
   logic         direct_wb, direct_dz;
   logic [2*W-1:0] direct_data;
   logic [W:0]   mul_sum, div_shift, div_diff;
   logic         div_ge;

   assign op_new   = op_e'(bus.op_in);
   assign start_ok = (state_q == StIdle) && bus.start_in && !bus.flush_in;
   assign enter_wb = (state_d == StWb) && (state_q != StWb);

   cus19_muldiv_signfix #(
      .Data_Width  (W),
      .Result_Side (1'b0)
   ) u_operand_fix (
      .op       (op_new),
      .sign_a   (bus.rs1_in[W-1]),
      .sign_b   (bus.rs2_in[W-1]),
      .lo       (bus.rs1_in),
      .hi       (bus.rs2_in),
      .lo_fixed (a_mag),
      .hi_fixed (b_mag)
   );

   cus19_muldiv_signfix #(
      .Data_Width  (W),
      .Result_Side (1'b1)
   ) u_result_fix (
      .op       (op_q),
      .sign_a   (sign_a_q),
      .sign_b   (sign_b_q),
      .lo       (lo_q),
      .hi       (hi_q),
      .lo_fixed (fix_lo),
      .hi_fixed (fix_hi)
   );

   // Ops resolved at issue time, skipping CALC/FIXUP entirely
   always_comb begin
      direct_wb   = 1'b0;
      direct_dz   = 1'b0;
      direct_data = '0;
      if (is_div(op_new) && (bus.rs2_in == '0)) begin
         direct_wb   = 1'b1;
         direct_dz   = 1'b1;
         direct_data = {bus.rs1_in, {W{1'b1}}};
      end
`ifdef CUS19_MULDIV_EARLY_OUT_EN
      else if (!is_div(op_new) && ((bus.rs1_in == '0) || (bus.rs2_in == '0))) begin
         direct_wb   = 1'b1;
         direct_data = '0;
      end else if (is_div(op_new) && (a_mag < b_mag)) begin
         // also covers a zero dividend
         direct_wb   = 1'b1;
         direct_data = {bus.rs1_in, {W{1'b0}}};
      end
`endif
   end

   // lo_q holds multiplier (MUL) or dividend/quotient (DIV); hi_q the running high half
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
   assign div_shift = {hi_q, lo_q[W-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_diff  = div_shift - {1'b0, b_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_ok) state_d = direct_wb ? StWb : StCalc;
         StCalc:  begin
            if (bus.flush_in)        state_d = StIdle;
            else if (cnt_q == '0)    state_d = StFixup;
         end
         StFixup: state_d = bus.flush_in ? StIdle : StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         op_q       <= OpMulu;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         rd_q       <= '0;
         wr_addr_q  <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  op_q       <= op_new;
                  sign_a_q   <= bus.rs1_in[W-1];
                  sign_b_q   <= bus.rs2_in[W-1];
                  lo_q       <= a_mag;
                  hi_q       <= '0;
                  b_q        <= b_mag;
                  cnt_q      <= Cnt_Init;
                  rd_q       <= bus.rd_addr_in;
                  div_zero_q <= direct_dz;
               end
               if (enter_wb) begin
                  result_q  <= direct_data;
                  wr_addr_q <= bus.rd_addr_in;
               end
            end
            StCalc: begin
               cnt_q <= cnt_q - 1'b1;
               if (is_div(op_q)) begin
                  hi_q <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                  lo_q <= {lo_q[W-2:0], div_ge};
               end else begin
                  hi_q <= mul_sum[W:1];
                  lo_q <= {mul_sum[0], lo_q[W-1:1]};
               end
            end
            StFixup: begin
               if (enter_wb) begin
                  result_q  <= {fix_hi, fix_lo};
                  wr_addr_q <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_out     = (state_q != StIdle);
   assign bus.wr_en_out    = (state_q == StWb);
   assign bus.done_out     = (state_q == StWb);
   assign bus.div_zero_out = (state_q == StWb) && div_zero_q;
   assign bus.wr_addr_out  = wr_addr_q;
   assign bus.wr_data_out  = result_q;

endmodule
